reel_spin_ctrl: RTL and testbench

- Parametrised motion controller for the slot-machine reel display. Owns the vertical scroll position of NUM_REELS reels, each a loop of SYMS_PER_REEL symbols of SYM_HEIGHT pixels.
- Each reel runs a per-reel FSM: fast spin, slow spin, snap-to-symbol alignment, stop. Stop times are staggered by reel index, with optional LFSR jitter.
- Sits between the VGA timing block, which supplies a frame tick, and the pattern generator, which consumes positions and symbol indices.

---
 rtl/reel_spin_if.sv | 25 ++
 rtl/reel_spin_ctrl.sv | 161 ++++++++++++++++
 tb/tb_reel_spin_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reel_spin_if.sv
// Frame-tick / start requests in, per-reel scroll positions and spin status out.
// master drives requests (timing/UI side), slave is the reel controller.
interface reel_spin_if #(
  parameter int NUM_REELS = 3,
  parameter int POS_W     = 9,
  parameter int SYM_W     = 2
);
  logic                       frame_tick;
  logic                       start;
  logic [NUM_REELS*POS_W-1:0] reel_pos;
  logic [NUM_REELS*SYM_W-1:0] reel_sym;
  logic [NUM_REELS-1:0]       reel_stopped;
  logic                       busy;
  logic                       done;

  modport master (
    output frame_tick, start,
    input  reel_pos, reel_sym, reel_stopped, busy, done
  );

  modport slave (
    input  frame_tick, start,
    output reel_pos, reel_sym, reel_stopped, busy, done
  );
endinterface

// File: rtl/reel_spin_ctrl.sv
// Reel motion controller: per-reel FAST/SLOW/ALIGN/STOPPED FSM, staggered stops, LFSR jitter.
// Registered outputs, one-cycle start-to-FAST; no backpressure, start is dropped while busy.
module reel_spin_ctrl #(
  parameter int          NUM_REELS      = 3,
  parameter int          SYMS_PER_REEL  = 4,
  parameter int          SYM_HEIGHT     = 120,
  parameter int          FAST_STEP      = 8,
  parameter int          SLOW_STEP      = 1,
  parameter int          FAST_FRAMES    = 600,
  parameter int          STAGGER_FRAMES = 120,
  parameter int          SLOW_FRAMES    = 60,
  parameter bit          JITTER_EN      = 1'b1,
  parameter int          JITTER_W       = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic      clk,
  input  logic      rst,
  reel_spin_if.slave bus
);
  localparam int REEL_LEN = SYMS_PER_REEL * SYM_HEIGHT;
  localparam int POS_W    = $clog2(REEL_LEN);
  localparam int SYM_W    = (SYMS_PER_REEL > 1) ? $clog2(SYMS_PER_REEL) : 1;
  localparam int MAX_FAST = FAST_FRAMES + (NUM_REELS - 1) * STAGGER_FRAMES + (1 << JITTER_W);
  localparam int MAX_CNT  = (MAX_FAST > SLOW_FRAMES) ? MAX_FAST : SLOW_FRAMES;
  localparam int CNT_W    = $clog2(MAX_CNT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FAST,
    S_SLOW,
    S_ALIGN,
    S_STOPPED
  } state_t;

  state_t              state_q [NUM_REELS];
  state_t              state_d [NUM_REELS];
  logic [POS_W-1:0]    pos_q   [NUM_REELS];
  logic [POS_W-1:0]    pos_d   [NUM_REELS];
  logic [CNT_W-1:0]    cnt_q   [NUM_REELS];
  logic [CNT_W-1:0]    cnt_d   [NUM_REELS];
  logic [JITTER_W-1:0] jit_q   [NUM_REELS];
  logic [JITTER_W-1:0] jit_d   [NUM_REELS];
  logic [NUM_REELS-1:0] stopped_q, stopped_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                accept;
  logic                all_stopped;
  logic [3:0]          tap_idx;
  int                  fast_len;

  // Add step and wrap back into 0..REEL_LEN-1; step is always below REEL_LEN.
  function automatic logic [POS_W-1:0] advance(input logic [POS_W-1:0] p, input int step);
    int s;
    s = int'(p) + step;
    if (s >= REEL_LEN) s = s - REEL_LEN;
    return s[POS_W-1:0];
  endfunction

  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    accept      = bus.start && !busy_q;
    all_stopped = 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tap_idx     = '0;
    fast_len    = 0;
    stopped_d   = '0;

    for (int i = 0; i < NUM_REELS; i++) begin
      if (state_q[i] != S_STOPPED) all_stopped = 1'b0;
    end

    // Completion is seen from registered state, so done trails the last stop by a cycle.
    if (accept) begin
      busy_d = 1'b1;
    end else if (busy_q && all_stopped) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    for (int i = 0; i < NUM_REELS; i++) begin
      state_d[i] = state_q[i];
      pos_d[i]   = pos_q[i];
      cnt_d[i]   = cnt_q[i];
      jit_d[i]   = jit_q[i];
      fast_len   = FAST_FRAMES + i * STAGGER_FRAMES + int'(jit_q[i]);

      if (accept) begin
        state_d[i] = S_FAST;
        cnt_d[i]   = '0;
        for (int b = 0; b < JITTER_W; b++) begin
          tap_idx     = 4'((i * JITTER_W + b) % 16);
          jit_d[i][b] = JITTER_EN ? lfsr_q[tap_idx] : 1'b0;
        end
      end else if (bus.frame_tick) begin
        case (state_q[i])
          S_FAST: begin
            pos_d[i] = advance(pos_q[i], FAST_STEP);
            if (int'(cnt_q[i]) == fast_len - 1) begin
              state_d[i] = S_SLOW;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          S_SLOW: begin
            pos_d[i] = advance(pos_q[i], SLOW_STEP);
            if (int'(cnt_q[i]) == SLOW_FRAMES - 1) begin
              state_d[i] = S_ALIGN;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          S_ALIGN: begin
            // Boundary test on the pre-step position: landing costs one extra tick.
            if ((int'(pos_q[i]) % SYM_HEIGHT) == 0) state_d[i] = S_STOPPED;
            else                                    pos_d[i]   = advance(pos_q[i], SLOW_STEP);
          end
          default: ;
        endcase
      end

      stopped_d[i] = (state_d[i] == S_IDLE) || (state_d[i] == S_STOPPED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REELS; i++) begin
        state_q[i] <= S_IDLE;
        pos_q[i]   <= '0;
        cnt_q[i]   <= '0;
        jit_q[i]   <= '0;
      end
      stopped_q <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      jit_q     <= jit_d;
      stopped_q <= stopped_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lfsr_q    <= lfsr_d;
    end
  end

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_out
    assign bus.reel_pos[g*POS_W +: POS_W] = pos_q[g];
    assign bus.reel_sym[g*SYM_W +: SYM_W] = SYM_W'(pos_q[g] / POS_W'(SYM_HEIGHT));
  end

  assign bus.reel_stopped = stopped_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Directed bench for reel_spin_ctrl: one instance without jitter (exact stop ticks), one with jitter.
module tb_reel_spin_ctrl;
  localparam int NR = 3;
  localparam int PW = 9;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reel_spin_if #(.NUM_REELS(NR), .POS_W(PW), .SYM_W(SW)) n_if ();
  reel_spin_if #(.NUM_REELS(NR), .POS_W(PW), .SYM_W(SW)) j_if ();

  reel_spin_ctrl #(.JITTER_EN(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(n_if.slave));
  reel_spin_ctrl #(.JITTER_EN(1'b1)) dut_j (.clk(clk), .rst(rst), .bus(j_if.slave));

  // Reference Galois LFSR (taps 16'hB400) used to predict the jitter latched at start.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int total = 0;
  int bad   = 0;

  int fast_len [NR];
  int stop_tick[NR];
  int final_pos[NR];
  int final_sym[NR];
  int start_pos[NR];
  int r0_pos   [0:1100];
  int start_busy, first_tick_pos0;
  int done_cnt, done_cyc, allstop_cyc, busy_at_done, busy_at_allstop;
  int max_pos, sym_err, timeout;
  bit wrap_seen;
  logic [15:0] lfsr_at_start;

  function automatic int get_pos(input bit sel, input int i);
    if (sel) return int'(j_if.reel_pos[i*PW +: PW]);
    return int'(n_if.reel_pos[i*PW +: PW]);
  endfunction

  function automatic int get_sym(input bit sel, input int i);
    if (sel) return int'(j_if.reel_sym[i*SW +: SW]);
    return int'(n_if.reel_sym[i*SW +: SW]);
  endfunction

  function automatic logic [NR-1:0] get_stopped(input bit sel);
    return sel ? j_if.reel_stopped : n_if.reel_stopped;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? j_if.busy : n_if.busy;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? j_if.done : n_if.done;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic tk);
    if (sel) begin
      j_if.start = st;
      j_if.frame_tick = tk;
    end else begin
      n_if.start = st;
      n_if.frame_tick = tk;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Start a spin, then alternate tick / idle cycles until done has been seen, recording per-reel timing.
  task automatic spin(input bit sel, input bit coinc, input int busy_start_tick);
    int prev[NR];
    int prev_sym[NR];
    bit in_fast[NR];
    int tick_no = 0;
    int cyc = 0;
    bit fin = 1'b0;
    int p, s, d;
    for (int i = 0; i < NR; i++) begin
      fast_len[i] = 0;
      stop_tick[i] = -1;
      in_fast[i] = 1'b1;
    end
    done_cnt = 0; done_cyc = -1; allstop_cyc = -1; busy_at_done = -1; busy_at_allstop = -1;
    max_pos = 0; sym_err = 0; timeout = 0; wrap_seen = 1'b0; first_tick_pos0 = -1;
    lfsr_at_start = m_lfsr;
    drive(sel, 1'b1, coinc);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0);
    start_busy = int'(get_busy(sel));
    for (int i = 0; i < NR; i++) begin
      prev[i] = get_pos(sel, i);
      prev_sym[i] = get_sym(sel, i);
      start_pos[i] = prev[i];
    end
    while (!fin) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) drive(sel, (tick_no + 1 == busy_start_tick), 1'b1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0);
        cyc++;
        if (ph == 0) tick_no++;
        for (int i = 0; i < NR; i++) begin
          p = get_pos(sel, i);
          s = get_sym(sel, i);
          if (p > max_pos) max_pos = p;
          if (s != p / 120) sym_err++;
          if (ph == 0) begin
            d = (p - prev[i] + 480) % 480;
            if (in_fast[i]) begin
              if (d == 8) fast_len[i]++;
              else in_fast[i] = 1'b0;
            end
            if (i == 0 && prev[i] == 472 && p == 0 && prev_sym[i] == 3 && s == 0) wrap_seen = 1'b1;
            if (i == 0 && tick_no <= 1100) r0_pos[tick_no] = p;
            if (i == 0 && tick_no == 1) first_tick_pos0 = p;
          end
          if (stop_tick[i] < 0 && get_stopped(sel)[i]) stop_tick[i] = tick_no;
          prev[i] = p;
          prev_sym[i] = s;
        end
        if (allstop_cyc < 0 && get_stopped(sel) == '1) begin
          allstop_cyc = cyc;
          busy_at_allstop = int'(get_busy(sel));
        end
        if (get_done(sel)) begin
          done_cnt++;
          if (done_cyc < 0) begin
            done_cyc = cyc;
            busy_at_done = int'(get_busy(sel));
          end
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc + 4) fin = 1'b1;
      if (tick_no > 1500) begin
        timeout = 1;
        fin = 1'b1;
      end
    end
    for (int i = 0; i < NR; i++) begin
      final_pos[i] = prev[i];
      final_sym[i] = prev_sym[i];
    end
  endtask

  task automatic test_reset();
    total++; if (n_if.reel_pos !== '0) begin bad++; $display("FAIL reset_pos: got %h expected 0", n_if.reel_pos); end
    total++; if (n_if.reel_sym !== '0) begin bad++; $display("FAIL reset_sym: got %h expected 0", n_if.reel_sym); end
    total++; if (n_if.reel_stopped !== 3'b111) begin bad++; $display("FAIL reset_stopped: got %b expected 111", n_if.reel_stopped); end
    total++; if (n_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", n_if.busy); end
    total++; if (n_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", n_if.done); end
    total++; if (j_if.reel_stopped !== 3'b111) begin bad++; $display("FAIL reset_j_stopped: got %b expected 111", j_if.reel_stopped); end
  endtask

  task automatic test_nominal();
    int exp_stop[NR] = '{721, 841, 961};
    do_reset();
    spin(1'b0, 1'b0, 0);
    total++; if (timeout != 0) begin bad++; $display("FAIL nom_timeout: got %0d expected 0", timeout); end
    total++; if (start_busy != 1) begin bad++; $display("FAIL nom_busy_after_start: got %0d expected 1", start_busy); end
    for (int i = 0; i < NR; i++) begin
      total++; if (fast_len[i] != 600 + 120 * i) begin bad++; $display("FAIL nom_fast_len[%0d]: got %0d expected %0d", i, fast_len[i], 600 + 120 * i); end
      total++; if (stop_tick[i] != exp_stop[i]) begin bad++; $display("FAIL nom_stop_tick[%0d]: got %0d expected %0d", i, stop_tick[i], exp_stop[i]); end
      total++; if (final_pos[i] != 120) begin bad++; $display("FAIL nom_final_pos[%0d]: got %0d expected 120", i, final_pos[i]); end
      total++; if (final_sym[i] != 1) begin bad++; $display("FAIL nom_final_sym[%0d]: got %0d expected 1", i, final_sym[i]); end
    end
    total++; if (r0_pos[600] != 0) begin bad++; $display("FAIL nom_r0_t600: got %0d expected 0", r0_pos[600]); end
    total++; if (r0_pos[660] != 60) begin bad++; $display("FAIL nom_r0_t660: got %0d expected 60", r0_pos[660]); end
    total++; if (r0_pos[720] != 120) begin bad++; $display("FAIL nom_r0_t720: got %0d expected 120", r0_pos[720]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL nom_done_count: got %0d expected 1", done_cnt); end
    total++; if (done_cyc != allstop_cyc + 1) begin bad++; $display("FAIL nom_done_cycle: got %0d expected %0d", done_cyc, allstop_cyc + 1); end
    total++; if (busy_at_allstop != 1) begin bad++; $display("FAIL nom_busy_at_allstop: got %0d expected 1", busy_at_allstop); end
    total++; if (busy_at_done != 0) begin bad++; $display("FAIL nom_busy_at_done: got %0d expected 0", busy_at_done); end
    total++; if (sym_err != 0) begin bad++; $display("FAIL nom_sym_decode: got %0d errors expected 0", sym_err); end
  endtask

  task automatic test_wrap();
    total++; if (wrap_seen !== 1'b1) begin bad++; $display("FAIL wrap_472_to_0: got %b expected 1", wrap_seen); end
    total++; if (max_pos >= 480) begin bad++; $display("FAIL wrap_max_pos: got %0d expected <480", max_pos); end
    total++; if (r0_pos[59] != 472) begin bad++; $display("FAIL wrap_r0_t59: got %0d expected 472", r0_pos[59]); end
  endtask

  task automatic test_busy_start();
    int exp_stop[NR] = '{721, 841, 961};
    do_reset();
    spin(1'b0, 1'b0, 300);
    for (int i = 0; i < NR; i++) begin
      total++; if (stop_tick[i] != exp_stop[i]) begin bad++; $display("FAIL busy_start_stop[%0d]: got %0d expected %0d", i, stop_tick[i], exp_stop[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_coincident();
    do_reset();
    spin(1'b0, 1'b1, 0);
    for (int i = 0; i < NR; i++) begin
      total++; if (start_pos[i] != 0) begin bad++; $display("FAIL coinc_pos[%0d]: got %0d expected 0", i, start_pos[i]); end
    end
    total++; if (first_tick_pos0 != 8) begin bad++; $display("FAIL coinc_first_step: got %0d expected 8", first_tick_pos0); end
    total++; if (stop_tick[0] != 721) begin bad++; $display("FAIL coinc_stop0: got %0d expected 721", stop_tick[0]); end
  endtask

  task automatic test_async_reset();
    int exp_stop[NR] = '{721, 841, 961};
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0);
    total++; if (get_pos(1'b0, 0) != 80) begin bad++; $display("FAIL arst_pre_pos: got %0d expected 80", get_pos(1'b0, 0)); end
    total++; if (n_if.reel_stopped !== 3'b000) begin bad++; $display("FAIL arst_pre_stopped: got %b expected 000", n_if.reel_stopped); end
    #2 rst = 1'b1;
    #1;
    total++; if (n_if.reel_pos !== '0) begin bad++; $display("FAIL arst_pos: got %h expected 0", n_if.reel_pos); end
    total++; if (n_if.busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b expected 0", n_if.busy); end
    total++; if (n_if.reel_stopped !== 3'b111) begin bad++; $display("FAIL arst_stopped: got %b expected 111", n_if.reel_stopped); end
    total++; if (n_if.done !== 1'b0) begin bad++; $display("FAIL arst_done: got %b expected 0", n_if.done); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    spin(1'b0, 1'b0, 0);
    for (int i = 0; i < NR; i++) begin
      total++; if (stop_tick[i] != exp_stop[i]) begin bad++; $display("FAIL arst_rerun_stop[%0d]: got %0d expected %0d", i, stop_tick[i], exp_stop[i]); end
    end
  endtask

  task automatic test_jitter();
    int l, p, a, jit;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      spin(1'b1, 1'b0, 0);
      total++; if (timeout != 0) begin bad++; $display("FAIL jit_timeout[run%0d]: got %0d expected 0", run, timeout); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL jit_done[run%0d]: got %0d expected 1", run, done_cnt); end
      for (int i = 0; i < NR; i++) begin
        jit = int'((lfsr_at_start >> (4 * i)) & 16'h000F);
        l = 600 + 120 * i + jit;
        p = (8 * l) % 480;
        p = (p + 60) % 480;
        a = (120 - (p % 120)) % 120;
        total++; if (fast_len[i] != l) begin bad++; $display("FAIL jit_fast_len[run%0d][%0d]: got %0d expected %0d", run, i, fast_len[i], l); end
        total++; if (fast_len[i] < 600 + 120 * i || fast_len[i] > 615 + 120 * i) begin bad++; $display("FAIL jit_fast_range[run%0d][%0d]: got %0d expected %0d..%0d", run, i, fast_len[i], 600 + 120 * i, 615 + 120 * i); end
        total++; if (stop_tick[i] != l + 60 + a + 1) begin bad++; $display("FAIL jit_stop_tick[run%0d][%0d]: got %0d expected %0d", run, i, stop_tick[i], l + 60 + a + 1); end
        total++; if (final_pos[i] != (p + a) % 480) begin bad++; $display("FAIL jit_final_pos[run%0d][%0d]: got %0d expected %0d", run, i, final_pos[i], (p + a) % 480); end
        total++; if (final_pos[i] % 120 != 0) begin bad++; $display("FAIL jit_aligned[run%0d][%0d]: got %0d expected multiple of 120", run, i, final_pos[i]); end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #3;
    test_reset();
    test_nominal();
    test_wrap();
    test_busy_start();
    test_coincident();
    test_async_reset();
    test_jitter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
